// File: rtl/add_ctrl_pkg.sv
// Shared types and default sizing for the nibble-serial adder controller.
package add_ctrl_pkg;

    localparam int DEF_NIBBLE_W   = 4;
    localparam int DEF_NUM_SLICES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nbit_adder.sv
// Narrow adder slice shared across time by the serial controller.
module nbit_adder #(
    parameter int NIBBLE_W = 4
) (
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder built from one NIBBLE_W slice reused over NUM_SLICES cycles.
// Optional signed-overflow output is enabled by defining ADD_OVF_DETECT_EN.
module nibble_serial_add_ctrl
    import add_ctrl_pkg::*;
#(
    parameter int NIBBLE_W   = DEF_NIBBLE_W,
    parameter int NUM_SLICES = DEF_NUM_SLICES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NIBBLE_W*NUM_SLICES-1:0] a,
    input  logic [NIBBLE_W*NUM_SLICES-1:0] b,
    input  logic                           cin,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NIBBLE_W*NUM_SLICES-1:0] sum,
    output logic                           cout,
    output logic                           busy
`ifdef ADD_OVF_DETECT_EN
    ,
    output logic                           ovf
`endif
);

    localparam int W     = NIBBLE_W * NUM_SLICES;
    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    state_t state_reg, state_next;

    logic [W-1:0]        a_reg, b_reg, sum_reg;
    logic                carry_reg, cout_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;
    logic                accept, last_slice;

    assign accept     = in_valid && in_ready;
    assign last_slice = (idx_reg == IDX_W'(NUM_SLICES - 1));

    nbit_adder #(
        .NIBBLE_W (NIBBLE_W)
    ) u_adder (
        .a    (a_reg[NIBBLE_W-1:0]),
        .b    (b_reg[NIBBLE_W-1:0]),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // in_ready is gated by rst_n so no operand is taken while reset is held.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result is assembled LSB-first: each slice lands at the top and the
    // register shifts right, so after the last slice it is fully aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx_reg   <= '0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_reg     <= a_reg >> NIBBLE_W;
            b_reg     <= b_reg >> NIBBLE_W;
            sum_reg   <= (sum_reg >> NIBBLE_W) | (W'(slice_sum) << (W - NIBBLE_W));
            carry_reg <= slice_cout;
            cout_reg  <= slice_cout;
            idx_reg   <= idx_reg + IDX_W'(1);
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

`ifdef ADD_OVF_DETECT_EN
    logic a_msb_reg, b_msb_reg, ovf_reg;

    // The final slice's top bit is the result MSB, so ovf is decided on that edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_msb_reg <= a[W-1];
            b_msb_reg <= b[W-1];
        end else if ((state_reg == RUN) && last_slice) begin
            ovf_reg <= (a_msb_reg == b_msb_reg) && (slice_sum[NIBBLE_W-1] != a_msb_reg);
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Sequencing controller that performs a wide (NIBBLE_W × NUM_SLICES bit) addition by time-multiplexing one narrow `nbit_adder` slice over successive cycles. It chains the carry between slices in a register. Operands enter and results leave on valid/ready handshakes. It sits between the board-level operand sources and the result register stage, replacing a wide combinational adder where area or timing matters more than throughput.

## Interface
- NIBBLE_W, 4, width of the shared adder slice
- NUM_SLICES, 4, slices per operand; total width W = NIBBLE_W*NUM_SLICES (≥1)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand set valid
- in_ready  out  1  controller can accept operands
- a  in  W  operand A
- b  in  W  operand B
- cin  in  1  carry into slice 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  W  registered result
- cout  out  1  carry out of the top slice
- busy  out  1  high in RUN or DONE
- ovf  out  1  signed overflow; present only with ADD_OVF_DETECT_EN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture a, b into operand shift registers, cin into carry reg, clear slice index, go to RUN.
- RUN: adder inputs are the low NIBBLE_W bits of the operand registers plus the carry reg. Each cycle:
  - shift the slice sum into the top of the sum shift register (shift right by NIBBLE_W);
  - shift the operand registers right by NIBBLE_W;
  - load the adder carry-out into the carry reg;
  - increment the index.
- Leaving RUN: when index == NUM_SLICES-1, that cycle's update completes the result and the FSM goes to DONE.
- DONE: out_valid=1; sum and cout are held stable. On out_ready, go to IDLE.
- in_ready is 0 in RUN and DONE. in_valid is ignored there and no operand is dropped or queued.
- Arithmetic is unsigned modulo 2^W with carry: {cout,sum} = a + b + cin.
- NUM_SLICES=1 is legal: RUN lasts one cycle.

## Timing
- Reset values: in_ready=0 during reset and 1 on the first cycle after. out_valid=0, busy=0, sum=0, cout=0, ovf=0. State=IDLE.
- Accept at edge k. out_valid goes high after edge k+NUM_SLICES.
- With out_ready held high, the FSM returns to IDLE after edge k+NUM_SLICES+1. The next accept is at edge k+NUM_SLICES+2. Minimum issue period is NUM_SLICES+2 cycles.
- out_ready low: the FSM stays in DONE indefinitely with outputs unchanged.
- out_ready high while out_valid=0 has no effect.
- rst_n low mid-operation, at any state: aborts on that edge with no out_valid pulse. The partial result is discarded and the registers return to reset values.
- sum, cout and ovf change only on a RUN-cycle edge or on reset.

## Configuration
- ADD_OVF_DETECT_EN defined:
  - at accept, the MSBs of a and b are also captured;
  - ovf is registered at the final RUN edge as (a_msb==b_msb) && (sum_msb!=a_msb);
  - ovf is valid with out_valid and held through DONE.
- Not defined: the ovf port, the MSB capture flops and the ovf logic are absent. Everything else is identical.

## Structure
- Package `add_ctrl_pkg` holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - default constants for NIBBLE_W and NUM_SLICES.
- The single sub-module is the existing `nbit_adder`, instantiated once with parameter NIBBLE_W. All sequencing, shift registers and the index counter live in this module.
- The index counter width is $clog2(NUM_SLICES), minimum 1.

## Test plan
- a=16'h1234, b=16'h4321, cin=0 → sum=16'h5555, cout=0. out_valid rises exactly 4 cycles after accept.
- a=16'hFFFF, b=16'h0000, cin=1 → sum=16'h0000, cout=1. Confirms carry ripples through all slices.
- a=16'h7FFF, b=16'h0001, cin=0 with ADD_OVF_DETECT_EN → sum=16'h8000, ovf=1. a=16'hFFFF, b=16'h0001 → sum=0, cout=1, ovf=0.
- Hold out_ready=0 for 10 cycles after result:
  - out_valid and sum stay stable;
  - in_ready stays 0;
  - an in_valid pulse with new operands is ignored and produces no extra result.
- Assert rst_n=0 during RUN (after slice 2) → next cycle all outputs at reset values, no out_valid. A new transaction then completes correctly.
- Back-to-back random transactions with in_valid and out_ready always high → issue period 6 cycles; every result matches a+b+cin against the reference model.
